readout_capture: RTL and testbench

- Sensor-side counterpart of the exposure controller. Consumes its Erase, Expose, NRE_1, NRE_2 and ADC strobes.
- Captures converted pixel words from the 2-row array on each ADC strobe and tags each word with row and column.
- Serialises the words into a small FIFO with a valid/ready output toward the frame store.
- Checks the strobe sequence and reports frame completion and protocol violations.

---
 rtl/readout_capture_pkg.sv | 13 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/readout_capture.sv | 145 ++++++++++++++
 tb/tb_readout_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/readout_capture_pkg.sv
// Shared types and sizing helpers for the readout capture path.
package readout_capture_pkg;

   typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, READ, DONE} state_t;

   // FIFO entry layout, MSB first: {last, row, col, data}
   function automatic int entry_width(input int data_w, input int cols);
      return data_w + 1 + $clog2(cols) + 1;
   endfunction

   localparam int ENTRY_W = entry_width(8, 2);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word that holds its value when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             do_wr;
   logic             do_rd;

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign do_rd      = rd_en & ~empty;
   assign do_wr      = wr_en & (~full | do_rd);
   assign rd_ptr_nxt = rd_ptr + PTR_W'(do_rd);
   assign count_nxt  = count + CNT_W'(do_wr) - CNT_W'(do_rd);
   // A word written into the slot that becomes the head must bypass the array
   assign head_nxt   = (do_wr && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         if (count_nxt != '0) rd_data <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/readout_capture.sv
// Captures converted pixel rows on ADC strobes, serialises them into a FIFO
// and polices the erase/expose/read strobe sequence.
module readout_capture
   import readout_capture_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int COLS       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Erase,
   input  logic                     Expose,
   input  logic                     NRE_1,
   input  logic                     NRE_2,
   input  logic                     ADC,
   input  logic [DATA_W*COLS-1:0]   Pix_data,
   output logic [DATA_W-1:0]        Out_data,
   output logic                     Out_row,
   output logic [$clog2(COLS)-1:0]  Out_col,
   output logic                     Out_last,
   output logic                     Out_valid,
   input  logic                     Out_ready,
   output logic                     Frame_done,
   output logic                     Proto_err
);

   localparam int COL_W  = $clog2(COLS);
   localparam int FIFO_W = entry_width(DATA_W, COLS);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

   state_t                     state;
   state_t                     state_nxt;
   logic                       adc_q;
   logic                       erase_q;
   logic                       adc_rise;
   logic                       erase_rise;
   logic [1:0]                 row_done;
   logic                       one_low;
   logic                       row_sel;
   logic                       capture;
   logic                       adc_err;
   logic                       drop_err;
   logic                       expose_err;
   logic                       ser_vld_p0;
   logic [COL_W-1:0]           ser_col_p0;
   logic                       cap_row_p0;
   logic [DATA_W*COLS-1:0]     cap_data_p0;
   logic                       ser_last;
   logic [FIFO_W-1:0]          wr_entry;
   logic [FIFO_W-1:0]          rd_entry;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   assign adc_rise   = ADC & ~adc_q;
   assign erase_rise = Erase & ~erase_q;
   assign one_low    = NRE_1 ^ NRE_2;
   // With exactly one enable low, NRE_1 high means row 2 is being read
   assign row_sel    = NRE_1;
   assign adc_err    = adc_rise & ((state != READ) | ~one_low | row_done[row_sel] | ser_vld_p0);
   assign capture    = adc_rise & ~Erase & ~adc_err;
   assign expose_err = (state == IDLE) & ~Erase & Expose;
   assign drop_err   = ser_vld_p0 & fifo_full & ~Out_ready;

   always_comb begin
      state_nxt  = state;
      Frame_done = 1'b0;
      case (state)
         IDLE:    state_nxt = IDLE;
         ERASE:   if (Expose) state_nxt = EXPOSE;
         EXPOSE:  if (!Expose) state_nxt = READ;
         READ:    if ((row_done == 2'b11) && !ser_vld_p0) state_nxt = DONE;
         DONE: begin
            Frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (Erase) state_nxt = ERASE;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         adc_q      <= 1'b0;
         erase_q    <= 1'b0;
         row_done   <= '0;
         ser_vld_p0 <= 1'b0;
         ser_col_p0 <= '0;
         cap_row_p0 <= 1'b0;
         Proto_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         adc_q   <= ADC;
         erase_q <= Erase;
         if (Erase) row_done <= '0;
         else if (capture) row_done[row_sel] <= 1'b1;
         // Erase aborts the serialiser but leaves queued words alone
         if (Erase) begin
            ser_vld_p0 <= 1'b0;
         end else if (capture) begin
            ser_vld_p0 <= 1'b1;
            ser_col_p0 <= '0;
            cap_row_p0 <= row_sel;
         end else if (ser_vld_p0) begin
            if (ser_col_p0 == LAST_COL) ser_vld_p0 <= 1'b0;
            else ser_col_p0 <= ser_col_p0 + COL_W'(1);
         end
         if (adc_err | drop_err | expose_err) Proto_err <= 1'b1;
         else if (erase_rise) Proto_err <= 1'b0;
      end
   end

   // stage p0: captured row, walked out one column per cycle
   always_ff @(posedge Clk) begin
      if (capture) cap_data_p0 <= Pix_data;
   end

   assign ser_last = cap_row_p0 & (ser_col_p0 == LAST_COL);
   assign wr_entry = {ser_last, cap_row_p0, ser_col_p0,
                      cap_data_p0[ser_col_p0*DATA_W +: DATA_W]};

   sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (Reset),
      .wr_en   (ser_vld_p0),
      .wr_data (wr_entry),
      .rd_en   (Out_ready),
      .rd_data (rd_entry),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign Out_valid = ~fifo_empty;
   assign Out_data  = rd_entry[DATA_W-1:0];
   assign Out_col   = rd_entry[DATA_W +: COL_W];
   assign Out_row   = rd_entry[DATA_W + COL_W];
   assign Out_last  = rd_entry[DATA_W + COL_W + 1];

endmodule

// File: tb/tb_readout_capture.sv
// Directed bench for readout_capture: one DEPTH-4 instance, one DEPTH-2 instance for overflow.
module tb_readout_capture;

   logic        clk;
   logic        rst_n;
   logic        erase;
   logic        expose;
   logic        nre_1;
   logic        nre_2;
   logic        adc;
   logic [15:0] pix;
   logic        rdy;
   logic        rdy2;
   logic [7:0]  out_data,  out_data2;
   logic        out_row,   out_row2;
   logic        out_col,   out_col2;
   logic        out_last,  out_last2;
   logic        out_valid, out_valid2;
   logic        frame_done, frame_done2;
   logic        proto_err,  proto_err2;

   int          n_checks = 0;
   int          n_errs   = 0;
   int          done_total = 0;
   logic [10:0] words [$];

   readout_capture #(.DATA_W(8), .COLS(2), .FIFO_DEPTH(4)) u_dut (
      .Clk(clk), .Reset(rst_n), .Erase(erase), .Expose(expose), .NRE_1(nre_1), .NRE_2(nre_2),
      .ADC(adc), .Pix_data(pix), .Out_data(out_data), .Out_row(out_row), .Out_col(out_col),
      .Out_last(out_last), .Out_valid(out_valid), .Out_ready(rdy), .Frame_done(frame_done),
      .Proto_err(proto_err)
   );

   readout_capture #(.DATA_W(8), .COLS(2), .FIFO_DEPTH(2)) u_dut2 (
      .Clk(clk), .Reset(rst_n), .Erase(erase), .Expose(expose), .NRE_1(nre_1), .NRE_2(nre_2),
      .ADC(adc), .Pix_data(pix), .Out_data(out_data2), .Out_row(out_row2), .Out_col(out_col2),
      .Out_last(out_last2), .Out_valid(out_valid2), .Out_ready(rdy2), .Frame_done(frame_done2),
      .Proto_err(proto_err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transfer log of the DEPTH-4 instance, packed {row, col, last, data}
   always @(posedge clk) begin
      if (rst_n && out_valid && rdy) words.push_back({out_row, out_col, out_last, out_data});
      if (frame_done) done_total <= done_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic prep_read();
      erase = 1'b1;
      cycles(2);
      erase  = 1'b0;
      expose = 1'b1;
      cycles(10);
      expose = 1'b0;
      cycles(2);
   endtask

   task automatic adc_pulse(input logic n1, input logic n2, input logic [15:0] p);
      nre_1 = n1;
      nre_2 = n2;
      pix   = p;
      adc   = 1'b1;
      cycles(1);
      adc   = 1'b0;
      nre_1 = 1'b1;
      nre_2 = 1'b1;
   endtask

   task automatic run_frame(input logic [15:0] p1, input logic [15:0] p2);
      prep_read();
      adc_pulse(1'b0, 1'b1, p1);
      cycles(4);
      adc_pulse(1'b1, 1'b0, p2);
   endtask

   task automatic check_frame(input string tag, input int base,
                              input logic [10:0] e0, input logic [10:0] e1,
                              input logic [10:0] e2, input logic [10:0] e3);
      chk({tag, "_count"}, words.size() - base, 4);
      chk({tag, "_w0"}, (words.size() > base)     ? words[base]     : 11'h7FF, e0);
      chk({tag, "_w1"}, (words.size() > base + 1) ? words[base + 1] : 11'h7FF, e1);
      chk({tag, "_w2"}, (words.size() > base + 2) ? words[base + 2] : 11'h7FF, e2);
      chk({tag, "_w3"}, (words.size() > base + 3) ? words[base + 3] : 11'h7FF, e3);
   endtask

   initial begin
      int base;
      int done_base;
      rst_n = 1'b0; erase = 1'b0; expose = 1'b0; nre_1 = 1'b1; nre_2 = 1'b1;
      adc = 1'b0; pix = '0; rdy = 1'b1; rdy2 = 1'b1;
      cycles(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", {out_row, out_col, out_last, out_data}, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", proto_err, 0);
      chk("rst_state", u_dut.state, readout_capture_pkg::IDLE);
      rst_n = 1'b1;
      cycles(2);

      // Full frame with the sink always ready
      base = words.size(); done_base = done_total;
      run_frame(16'hA1B0, 16'hD3C2);
      cycles(8);
      check_frame("full", base, 11'h0B0, 11'h2A1, 11'h4C2, 11'h7D3);
      chk("full_done", done_total - done_base, 1);
      chk("full_err", proto_err, 0);
      chk("full_drained", out_valid, 0);

      // Backpressure on DEPTH 4, overflow on DEPTH 2
      rdy = 1'b0; rdy2 = 1'b0;
      base = words.size(); done_base = done_total;
      run_frame(16'hA1B0, 16'hD3C2);
      cycles(7);
      chk("bp_count", u_dut.u_fifo.count, 4);
      chk("bp_head", out_data, 8'hB0);
      chk("bp_done_early", done_total - done_base, 1);
      chk("bp_err", proto_err, 0);
      chk("ovf_count", u_dut2.u_fifo.count, 2);
      chk("ovf_err", proto_err2, 1);
      chk("ovf_head", out_data2, 8'hB0);
      rdy = 1'b1;
      cycles(6);
      check_frame("bp", base, 11'h0B0, 11'h2A1, 11'h4C2, 11'h7D3);
      chk("bp_drained", out_valid, 0);
      chk("ovf_count_hold", u_dut2.u_fifo.count, 2);
      rdy2 = 1'b1;
      cycles(1);
      rdy2 = 1'b0;
      chk("ovf_second", {out_valid2, out_data2}, 9'h1A1);
      chk("ovf_count_1", u_dut2.u_fifo.count, 1);
      rdy2 = 1'b1;
      cycles(2);

      // Illegal strobes
      chk("idle_state", u_dut.state, readout_capture_pkg::IDLE);
      adc_pulse(1'b1, 1'b1, 16'h1234);
      cycles(1);
      chk("idle_adc_err", proto_err, 1);
      erase = 1'b1;
      cycles(1);
      chk("erase_clr", proto_err, 0);
      erase = 1'b0;
      prep_read();
      adc_pulse(1'b0, 1'b0, 16'h5678);
      cycles(3);
      chk("both_low_err", proto_err, 1);
      chk("both_low_nowr", u_dut.u_fifo.count, 0);
      erase = 1'b1;
      cycles(1);
      chk("erase_clr2", proto_err, 0);
      erase = 1'b0;

      // Abort mid-serialisation
      base = words.size();
      prep_read();
      adc_pulse(1'b0, 1'b1, 16'h6655);
      erase = 1'b1;
      cycles(1);
      chk("abort_state", u_dut.state, readout_capture_pkg::ERASE);
      erase = 1'b0;
      cycles(3);
      chk("abort_count", words.size() - base, 1);
      chk("abort_word", (words.size() > base) ? words[base] : 11'h7FF, 11'h055);
      base = words.size();
      run_frame(16'h2211, 16'h4433);
      cycles(8);
      check_frame("post", base, 11'h011, 11'h222, 11'h433, 11'h744);

      // Asynchronous reset mid-READ with two words queued
      rdy = 1'b0;
      prep_read();
      adc_pulse(1'b0, 1'b1, 16'h9988);
      cycles(2);
      chk("pre_rst_count", u_dut.u_fifo.count, 2);
      chk("pre_rst_head", {out_valid, out_data}, 9'h188);
      adc_pulse(1'b0, 1'b0, 16'h0000);
      chk("pre_rst_err", proto_err, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_state", u_dut.state, readout_capture_pkg::IDLE);
      chk("arst_err", proto_err, 0);
      chk("arst_data", out_data, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
